// File: rtl/apb2wb_bridge.sv
// APB3 slave to Wishbone classic master bridge with one outstanding access.
// All bus-facing outputs are registered. A Wishbone error or a timeout
// returns PSLVERR, so a missing peripheral cannot stall the APB side.
module apb2wb_bridge #(
    parameter int AW        = 12,
    parameter bit BYTE_MODE = 1'b1,
    parameter int TIMEOUT   = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] i_paddr,
    input  logic          i_psel,
    input  logic          i_penable,
    input  logic          i_pwrite,
    input  logic [31:0]   i_pwdata,
    output logic [31:0]   o_prdata,
    output logic          o_pready,
    output logic          o_pslverr,
    output logic [AW-3:0] o_wb_adr,
    output logic [31:0]   o_wb_dat,
    output logic [3:0]    o_wb_sel,
    output logic          o_wb_we,
    output logic          o_wb_cyc,
    output logic          o_wb_stb,
    input  logic [31:0]   i_wb_rdt,
    input  logic          i_wb_ack,
    input  logic          i_wb_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WB   = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Last counter value before abort; TIMEOUT=1 aborts in the first WB cycle.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    // Write lanes: an 8-bit peripheral sees the byte on every lane.
    function automatic logic [31:0] wr_lanes(input logic [31:0] wd);
        if (BYTE_MODE) begin
            wr_lanes = {4{wd[7:0]}};
        end else begin
            wr_lanes = wd;
        end
    endfunction

    // Byte select follows the byte offset only for 8-bit peripherals.
    function automatic logic [3:0] sel_for(input logic [1:0] ofs);
        if (BYTE_MODE) begin
            sel_for = 4'b0001 << ofs;
        end else begin
            sel_for = 4'b1111;
        end
    endfunction

    // Read data: 8-bit peripherals return only bits 7:0, zero-extended.
    function automatic logic [31:0] rd_data(input logic [31:0] rdt);
        if (BYTE_MODE) begin
            rd_data = {24'd0, rdt[7:0]};
        end else begin
            rd_data = rdt;
        end
    endfunction

    state_t        state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [AW-3:0] adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;
    logic [3:0]    sel_q, sel_d;
    logic          we_q, we_d;
    logic          cyc_q, cyc_d;
    logic          pready_q, pready_d;
    logic          pslverr_q, pslverr_d;
    logic [31:0]   prdata_q, prdata_d;

    // Next-state and next-output logic; pready only rises on the WB exit edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        we_d      = we_q;
        cyc_d     = cyc_q;
        pready_d  = 1'b0;
        pslverr_d = pslverr_q;
        prdata_d  = prdata_q;
        case (state_q)
            ST_IDLE: begin
                pslverr_d = 1'b0;
                if (i_psel && i_penable && !pready_q) begin
                    adr_d   = i_paddr[AW-1:2];
                    dat_d   = wr_lanes(i_pwdata);
                    sel_d   = sel_for(i_paddr[1:0]);
                    we_d    = i_pwrite;
                    cyc_d   = 1'b1;
                    cnt_d   = 16'd0;
                    state_d = ST_WB;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WB: begin
                if (i_wb_err) begin
                    cyc_d     = 1'b0;
                    pready_d  = 1'b1;
                    pslverr_d = 1'b1;
                    prdata_d  = 32'd0;
                    state_d   = ST_RESP;
                end else if (i_wb_ack) begin
                    cyc_d     = 1'b0;
                    pready_d  = 1'b1;
                    pslverr_d = 1'b0;
                    prdata_d  = rd_data(i_wb_rdt);
                    state_d   = ST_RESP;
                end else if (cnt_q >= TO_LAST) begin
                    cyc_d     = 1'b0;
                    pready_d  = 1'b1;
                    pslverr_d = 1'b1;
                    prdata_d  = 32'd0;
                    state_d   = ST_RESP;
                end else if (cnt_q != 16'hFFFF) begin
                    cnt_d = cnt_q + 16'd1;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_RESP: begin
                pslverr_d = 1'b0;
                state_d   = ST_IDLE;
            end
            default: begin
                cyc_d     = 1'b0;
                pslverr_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears every output immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 16'd0;
            adr_q     <= '0;
            dat_q     <= 32'd0;
            sel_q     <= 4'd0;
            we_q      <= 1'b0;
            cyc_q     <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            we_q      <= we_d;
            cyc_q     <= cyc_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

    assign o_prdata  = prdata_q;
    assign o_pready  = pready_q;
    assign o_pslverr = pslverr_q;
    assign o_wb_adr  = adr_q;
    assign o_wb_dat  = dat_q;
    assign o_wb_sel  = sel_q;
    assign o_wb_we   = we_q;
    assign o_wb_cyc  = cyc_q;
    assign o_wb_stb  = cyc_q;

endmodule

// File: tb/tb_apb2wb_bridge.sv
// Directed bench for apb2wb_bridge: a byte-mode and a word-mode instance
// share one APB master and one Wishbone responder driven from tasks.
module tb_apb2wb_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] paddr = 12'd0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] pwdata = 32'd0;
    logic [31:0] wb_rdt = 32'd0;
    logic        wb_ack = 1'b0, wb_err = 1'b0;

    logic [31:0] prdata_b, prdata_w, dat_b, dat_w;
    logic        pready_b, pready_w, pslverr_b, pslverr_w;
    logic [9:0]  adr_b, adr_w;
    logic [3:0]  sel_b, sel_w;
    logic        we_b, we_w, cyc_b, cyc_w, stb_b, stb_w;

    int errors = 0;
    int checks = 0;

    // results of the last apb_xfer call
    int          r_lat, r_ncyc;
    logic        r_pslverr_b, r_pslverr_w, r_we_b, r_after;
    logic [31:0] r_prdata_b, r_prdata_w, r_dat_b, r_dat_w;
    logic [9:0]  r_adr_b;
    logic [3:0]  r_sel_b, r_sel_w;

    always #5 clk = ~clk;

    apb2wb_bridge #(.AW(12), .BYTE_MODE(1'b1), .TIMEOUT(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .i_paddr(paddr), .i_psel(psel), .i_penable(penable),
        .i_pwrite(pwrite), .i_pwdata(pwdata), .o_prdata(prdata_b), .o_pready(pready_b),
        .o_pslverr(pslverr_b), .o_wb_adr(adr_b), .o_wb_dat(dat_b), .o_wb_sel(sel_b),
        .o_wb_we(we_b), .o_wb_cyc(cyc_b), .o_wb_stb(stb_b), .i_wb_rdt(wb_rdt),
        .i_wb_ack(wb_ack), .i_wb_err(wb_err));

    apb2wb_bridge #(.AW(12), .BYTE_MODE(1'b0), .TIMEOUT(8)) dut_w (
        .clk(clk), .rst_n(rst_n), .i_paddr(paddr), .i_psel(psel), .i_penable(penable),
        .i_pwrite(pwrite), .i_pwdata(pwdata), .o_prdata(prdata_w), .o_pready(pready_w),
        .o_pslverr(pslverr_w), .o_wb_adr(adr_w), .o_wb_dat(dat_w), .o_wb_sel(sel_w),
        .o_wb_we(we_w), .o_wb_cyc(cyc_w), .o_wb_stb(stb_w), .i_wb_rdt(wb_rdt),
        .i_wb_ack(wb_ack), .i_wb_err(wb_err));

    // One APB access; ack_cyc/err_cyc = WB cycle (1-based) carrying ack/err, 0 = never.
    // r_lat counts negedges from penable to the pready sample.
    task automatic apb_xfer(input logic [11:0] addr, input logic wr, input logic [31:0] wd,
                            input int ack_cyc, input int err_cyc, input logic [31:0] rdt);
        bit done;
        done = 1'b0;
        r_ncyc = 0;
        r_lat = 0;
        @(negedge clk);
        paddr = addr; pwrite = wr; pwdata = wd; psel = 1'b1; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        for (int i = 1; i <= 40 && !done; i++) begin
            @(negedge clk);
            if (pready_b) begin
                r_lat = i;
                r_pslverr_b = pslverr_b; r_pslverr_w = pslverr_w;
                r_prdata_b = prdata_b; r_prdata_w = prdata_w;
                psel = 1'b0; penable = 1'b0; wb_ack = 1'b0; wb_err = 1'b0;
                done = 1'b1;
            end else if (cyc_b) begin
                r_ncyc++;
                if (r_ncyc == 1) begin
                    r_adr_b = adr_b; r_dat_b = dat_b; r_sel_b = sel_b; r_we_b = we_b;
                    r_dat_w = dat_w; r_sel_w = sel_w;
                end
                wb_ack = (r_ncyc == ack_cyc);
                wb_err = (r_ncyc == err_cyc);
                wb_rdt = (r_ncyc == ack_cyc) ? rdt : 32'hFFFF_FFFF;
            end else begin
                wb_ack = 1'b0; wb_err = 1'b0;
            end
        end
        if (!done) begin
            errors++;
            $display("FAIL xfer_no_pready: got no pready within 40 cycles, expected a response");
            psel = 1'b0; penable = 1'b0; wb_ack = 1'b0; wb_err = 1'b0;
        end
        checks++;
        @(negedge clk);
        r_after = pready_b | pready_w | cyc_b | cyc_w;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++;
        if ({prdata_b, pready_b, pslverr_b, adr_b, dat_b, sel_b, we_b, cyc_b, stb_b} !== '0) begin
            errors++; $display("FAIL reset_byte: got nonzero outputs, expected all 0");
        end
        checks++;
        if ({prdata_w, pready_w, pslverr_w, adr_w, dat_w, sel_w, we_w, cyc_w, stb_w} !== '0) begin
            errors++; $display("FAIL reset_word: got nonzero outputs, expected all 0");
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_setup_only;
        paddr = 12'h004; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (cyc_b !== 1'b0 || cyc_w !== 1'b0) begin
            errors++; $display("FAIL setup_only: got cyc=%b/%b expected 0", cyc_b, cyc_w);
        end
        psel = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero_wait_write;
        apb_xfer(12'h00C, 1'b1, 32'h0000_00A5, 1, 0, 32'h0);
        checks++;
        if (r_adr_b !== 10'd3) begin errors++; $display("FAIL zw_adr: got %0d expected 3", r_adr_b); end
        checks++;
        if (r_dat_b !== 32'hA5A5_A5A5) begin errors++; $display("FAIL zw_dat: got %h expected a5a5a5a5", r_dat_b); end
        checks++;
        if (r_we_b !== 1'b1 || r_sel_b !== 4'b0001) begin
            errors++; $display("FAIL zw_we_sel: got we=%b sel=%b expected 1/0001", r_we_b, r_sel_b);
        end
        checks++;
        if (r_lat !== 2 || r_ncyc !== 1) begin
            errors++; $display("FAIL zw_latency: got lat=%0d cyc=%0d expected 2/1", r_lat, r_ncyc);
        end
        checks++;
        if (r_pslverr_b !== 1'b0 || r_after !== 1'b0) begin
            errors++; $display("FAIL zw_resp: got pslverr=%b after=%b expected 0/0", r_pslverr_b, r_after);
        end
    endtask

    task automatic test_wait_read;
        apb_xfer(12'h014, 1'b0, 32'h0, 4, 0, 32'h1234_5660);
        checks++;
        if (r_lat !== 5 || r_ncyc !== 4) begin
            errors++; $display("FAIL wr_latency: got lat=%0d cyc=%0d expected 5/4", r_lat, r_ncyc);
        end
        checks++;
        if (r_prdata_b !== 32'h0000_0060) begin errors++; $display("FAIL wr_prdata_b: got %h expected 00000060", r_prdata_b); end
        checks++;
        if (r_prdata_w !== 32'h1234_5660) begin errors++; $display("FAIL wr_prdata_w: got %h expected 12345660", r_prdata_w); end
        checks++;
        if (r_pslverr_b !== 1'b0 || r_adr_b !== 10'd5 || r_we_b !== 1'b0) begin
            errors++; $display("FAIL wr_misc: got pslverr=%b adr=%0d we=%b expected 0/5/0", r_pslverr_b, r_adr_b, r_we_b);
        end
        checks++;
        if (prdata_b !== 32'h0000_0060) begin errors++; $display("FAIL wr_hold: got %h expected 00000060", prdata_b); end
    endtask

    task automatic test_error;
        apb_xfer(12'h018, 1'b0, 32'h0, 2, 2, 32'h5555_5555);
        checks++;
        if (r_pslverr_b !== 1'b1 || r_prdata_b !== 32'd0 || r_prdata_w !== 32'd0) begin
            errors++; $display("FAIL err_resp: got pslverr=%b prdata=%h expected 1/0", r_pslverr_b, r_prdata_b);
        end
        checks++;
        if (r_lat !== 3 || r_after !== 1'b0) begin
            errors++; $display("FAIL err_pulse: got lat=%0d after=%b expected 3/0", r_lat, r_after);
        end
    endtask

    task automatic test_timeout;
        apb_xfer(12'h01C, 1'b0, 32'h0, 0, 0, 32'h0);
        checks++;
        if (r_ncyc !== 8) begin errors++; $display("FAIL to_cycles: got %0d expected 8", r_ncyc); end
        checks++;
        if (r_pslverr_b !== 1'b1 || r_pslverr_w !== 1'b1 || r_prdata_b !== 32'd0) begin
            errors++; $display("FAIL to_resp: got pslverr=%b prdata=%h expected 1/0", r_pslverr_b, r_prdata_b);
        end
        apb_xfer(12'h020, 1'b0, 32'h0, 1, 0, 32'h0000_0077);
        checks++;
        if (r_pslverr_b !== 1'b0 || r_prdata_b !== 32'h77 || r_ncyc !== 1) begin
            errors++; $display("FAIL to_recover: got pslverr=%b prdata=%h expected 0/77", r_pslverr_b, r_prdata_b);
        end
    endtask

    task automatic test_reset_mid;
        int seen;
        seen = 0;
        @(negedge clk);
        paddr = 12'h010; pwrite = 1'b1; pwdata = 32'h1111_1111; psel = 1'b1; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        for (int i = 0; i < 10 && seen < 2; i++) begin
            @(negedge clk);
            if (cyc_b) seen++;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({cyc_b, stb_b, pready_b, cyc_w, stb_w, pready_w} !== 6'd0 || seen !== 2) begin
            errors++; $display("FAIL rst_mid: got cyc/stb/pready=%b%b%b seen=%0d expected 000/2", cyc_b, stb_b, pready_b, seen);
        end
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (pready_b !== 1'b0 || cyc_b !== 1'b0) begin
            errors++; $display("FAIL rst_quiet: got pready=%b cyc=%b expected 0/0", pready_b, cyc_b);
        end
        apb_xfer(12'h008, 1'b1, 32'hDEAD_BEEF, 1, 0, 32'h0);
        checks++;
        if (r_dat_w !== 32'hDEAD_BEEF || r_sel_w !== 4'b1111) begin
            errors++; $display("FAIL rst_fresh: got dat=%h sel=%b expected deadbeef/1111", r_dat_w, r_sel_w);
        end
        checks++;
        if (r_pslverr_w !== 1'b0 || r_ncyc !== 1) begin
            errors++; $display("FAIL rst_fresh_resp: got pslverr=%b cyc=%0d expected 0/1", r_pslverr_w, r_ncyc);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] mem [10];
        logic [11:0] addr;
        logic [1:0]  low;
        int w;
        for (int i = 0; i < 10; i++) begin
            low  = 2'($urandom_range(0, 3));
            addr = 12'(12'h100 + i * 16) | {10'd0, low};
            mem[i] = $urandom;
            w = $urandom_range(0, 4);
            apb_xfer(addr, 1'b1, mem[i], w + 1, 0, 32'h0);
            checks++;
            if (r_ncyc !== w + 1 || r_lat !== w + 2 || r_after !== 1'b0) begin
                errors++; $display("FAIL b2b_wr_%0d: got cyc=%0d lat=%0d after=%b expected %0d/%0d/0", i, r_ncyc, r_lat, r_after, w + 1, w + 2);
            end
            checks++;
            if (r_dat_b !== {4{mem[i][7:0]}} || r_sel_b !== (4'b0001 << low)) begin
                errors++; $display("FAIL b2b_lanes_%0d: got dat=%h sel=%b", i, r_dat_b, r_sel_b);
            end
            w = $urandom_range(0, 4);
            apb_xfer(addr, 1'b0, 32'h0, w + 1, 0, mem[i]);
            checks++;
            if (r_ncyc !== w + 1 || r_lat !== w + 2 || r_after !== 1'b0) begin
                errors++; $display("FAIL b2b_rd_%0d: got cyc=%0d lat=%0d after=%b expected %0d/%0d/0", i, r_ncyc, r_lat, r_after, w + 1, w + 2);
            end
            checks++;
            if (r_prdata_b !== {24'd0, mem[i][7:0]} || r_prdata_w !== mem[i] || r_pslverr_b !== 1'b0) begin
                errors++; $display("FAIL b2b_rdata_%0d: got %h/%h expected %h", i, r_prdata_b, r_prdata_w, mem[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_setup_only();
        test_zero_wait_write();
        test_wait_read();
        test_error();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
